// File: rtl/stdby_seq_ctrl_pkg.sv
// Shared state encoding and helpers for the user standby sequencer.
// Encodings are fixed because pwr_ctrl benches decode the state by value.
package stdby_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SLEEP = 3'd3,
    S_WAKE  = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus stability counter.
// Output level follows the pressed state once it has held 2**DEB_W cycles; rise pulses on press.
module btn_debounce #(
  parameter int DEB_W = 4
) (
  input  logic clk_osc,
  input  logic rst,
  input  logic pin_n,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk_osc or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], ~pin_n};
      rise <= 1'b0;
      // any return to the current level restarts the stability window
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stdby_seq_ctrl.sv
// User standby sequencer: decides standby entry (button or idle timeout), pulses USERSTDBY,
// confirms via SFLAG, pulses CLRFLAG after wake and holds off new requests for a guard time.
module stdby_seq_ctrl
  import stdby_seq_ctrl_pkg::*;
#(
  parameter int DEB_W  = 4,
  parameter int IDLE_W = 20,
  parameter int ACK_TO = 64,
  parameter int GUARD  = 256
) (
  input  logic       clk_osc,
  input  logic       rst,
  input  logic       stdby_req_n,
  input  logic       activity,
  input  logic       sflag,
  input  logic       clr_err,
  output logic       user_stdby,
  output logic       clr_flag,
  output logic       in_stdby,
  output logic       err,
  output logic [7:0] stdby_cnt
);

  localparam int ACK_W = $clog2(ACK_TO + 1);
  localparam int GRD_W = $clog2(GUARD + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TO - 1);
  localparam logic [GRD_W-1:0]  GRD_LOAD  = GRD_W'(GUARD - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

  state_t            state, state_nxt;
  logic [1:0]        sflag_sync;
  logic              sflag_s;
  logic              deb_lvl, deb_rise, req_evt;
  logic [IDLE_W-1:0] idle;
  logic [ACK_W-1:0]  ack;
  logic [GRD_W-1:0]  guard;
  logic              ack_to;

  btn_debounce #(.DEB_W(DEB_W)) u_deb (
    .clk_osc (clk_osc),
    .rst     (rst),
    .pin_n   (stdby_req_n),
    .level   (deb_lvl),
    .rise    (deb_rise)
  );

  assign req_evt = deb_rise & deb_lvl;
  assign sflag_s = sflag_sync[1];
  // sflag on the last wait cycle counts as an ack, so timeout requires it low
  assign ack_to  = (state == S_WAIT) && !sflag_s && (ack == ACK_LAST);

  always_ff @(posedge clk_osc or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (req_evt || (idle == IDLE_MAX && !activity)) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (sflag_s) state_nxt = S_SLEEP;
               else if (ack == ACK_LAST) state_nxt = S_RUN;
      S_SLEEP: if (!sflag_s) state_nxt = S_WAKE;
      S_WAKE:  state_nxt = S_GUARD;
      S_GUARD: if (guard == '0) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_osc or negedge rst) begin
    if (!rst) begin
      sflag_sync <= '0;
      idle       <= '0;
      ack        <= '0;
      guard      <= '0;
      user_stdby <= 1'b0;
      clr_flag   <= 1'b0;
      in_stdby   <= 1'b0;
      err        <= 1'b0;
      stdby_cnt  <= '0;
    end else begin
      sflag_sync <= {sflag_sync[0], sflag};
      // outputs decode the next state so they line up with the state register
      user_stdby <= (state_nxt == S_REQ);
      clr_flag   <= (state_nxt == S_WAKE);
      in_stdby   <= (state_nxt == S_SLEEP);
      case (state)
        S_RUN: begin
          if (activity)             idle <= '0;
          else if (idle != IDLE_MAX) idle <= idle + 1'b1;
        end
        S_REQ:   ack <= '0;
        S_WAIT: begin
          ack <= ack + 1'b1;
          if (ack_to) idle <= '0;
        end
        S_WAKE:  guard <= GRD_LOAD;
        S_GUARD: begin
          if (guard == '0) idle  <= '0;
          else             guard <= guard - 1'b1;
        end
        default: ;
      endcase
      if (ack_to)       err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (state_nxt == S_WAKE) stdby_cnt <= sat_inc8(stdby_cnt);
    end
  end

endmodule

// File: tb/tb_stdby_seq_ctrl.sv
// Directed bench for stdby_seq_ctrl with small parameters; cycle counts are from reset release.
module tb_stdby_seq_ctrl;

  logic       clk_osc = 1'b0;
  logic       rst = 1'b0;
  logic       stdby_req_n = 1'b1;
  logic       activity = 1'b0;
  logic       sflag = 1'b0;
  logic       clr_err = 1'b0;
  logic       user_stdby, clr_flag, in_stdby, err;
  logic [7:0] stdby_cnt;

  int n_chk = 0;
  int n_fail = 0;

  stdby_seq_ctrl #(.DEB_W(2), .IDLE_W(4), .ACK_TO(8), .GUARD(6)) dut (
    .clk_osc     (clk_osc),
    .rst         (rst),
    .stdby_req_n (stdby_req_n),
    .activity    (activity),
    .sflag       (sflag),
    .clr_err     (clr_err),
    .user_stdby  (user_stdby),
    .clr_flag    (clr_flag),
    .in_stdby    (in_stdby),
    .err         (err),
    .stdby_cnt   (stdby_cnt)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct {
    bit         rs;
    bit         req_n, act, sfl, clr;
    int         n;
    bit         e_user, e_clr, e_in, e_err;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rs, bit req_n, bit act, bit sfl, bit clr, int n,
                              bit eu, bit ec, bit ei, bit ee, logic [7:0] ecnt);
    vec_t v;
    v.rs = rs; v.req_n = req_n; v.act = act; v.sfl = sfl; v.clr = clr; v.n = n;
    v.e_user = eu; v.e_clr = ec; v.e_in = ei; v.e_err = ee; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_osc);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // assert reset for two edges; release lands just after an edge so the next edge is cycle 1
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk_osc);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_sig(input int which, input string nm, input int lim);
    bit hit = 1'b0;
    for (int k = 0; k < lim && !hit; k++) begin
      step(1);
      case (which)
        0:       hit = user_stdby;
        1:       hit = in_stdby;
        2:       hit = clr_flag;
        default: hit = 1'b0;
      endcase
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_%s: got no pulse within %0d cycles, required one", nm, lim);
    end
  endtask

  // count user_stdby pulses over n cycles, then expect exactly `exp`
  task automatic count_user(input string nm, input int n, input int exp);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (user_stdby) c++;
    end
    chk8(nm, 8'(c), 8'(exp));
  endtask

  task automatic sleep_cycle();
    wait_sig(0, "user", 40);
    sflag = 1'b1;
    wait_sig(1, "in", 10);
    sflag = 1'b0;
    wait_sig(2, "clr", 10);
  endtask

  initial begin
    // rs req act sfl clr  n   user clr in err cnt
    // button request, ack timeout, err clear, idle timeout, clr_err vs timeout
    tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 6, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 7, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 4, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 6, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,1, 1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 4, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 8, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1, 1, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 1, 0,0,0,1,0));
    // pure idle timeout
    tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,15, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1, 1,0,0,0,0));
    // synced sflag lands on the last wait cycle: sleep, no error
    tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 7, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 6, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1, 0,0,1,0,0));
    // full sleep cycle; button re-press lands inside the guard and is dropped
    tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 7, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0, 2, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0, 1, 0,0,1,0,0));
    tbl.push_back(mk(0,1,0,1,0, 5, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 2, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 3, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 4, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,14, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1, 1,0,0,0,1));

    foreach (tbl[i]) begin
      stdby_req_n = tbl[i].req_n;
      activity    = tbl[i].act;
      sflag       = tbl[i].sfl;
      clr_err     = tbl[i].clr;
      if (tbl[i].rs) do_reset();
      if (tbl[i].n > 0) step(tbl[i].n);
      chk1($sformatf("row%0d.user_stdby", i), user_stdby, tbl[i].e_user);
      chk1($sformatf("row%0d.clr_flag", i),   clr_flag,   tbl[i].e_clr);
      chk1($sformatf("row%0d.in_stdby", i),   in_stdby,   tbl[i].e_in);
      chk1($sformatf("row%0d.err", i),        err,        tbl[i].e_err);
      chk8($sformatf("row%0d.stdby_cnt", i),  stdby_cnt,  tbl[i].e_cnt);
    end

    // reset while waiting for ack: outputs clear at once, next entry needs a full timeout
    step(2);
    rst = 1'b0;
    #1;
    chk8("rst_wait.cnt", stdby_cnt, 8'd0);
    chk1("rst_wait.user", user_stdby, 1'b0);
    chk1("rst_wait.in", in_stdby, 1'b0);
    stdby_req_n = 1'b1;
    repeat (2) @(posedge clk_osc);
    #1;
    rst = 1'b1;
    count_user("rst_wait.no_early_req", 15, 0);
    step(1);
    chk1("rst_wait.timeout_req", user_stdby, 1'b1);

    // reset during guard
    sflag = 1'b1;
    wait_sig(1, "in", 10);
    sflag = 1'b0;
    wait_sig(2, "clr", 10);
    chk8("guard.cnt_before", stdby_cnt, 8'd1);
    step(2);
    rst = 1'b0;
    #1;
    chk8("rst_guard.cnt", stdby_cnt, 8'd0);
    chk1("rst_guard.clr", clr_flag, 1'b0);
    repeat (2) @(posedge clk_osc);
    #1;
    rst = 1'b1;
    count_user("rst_guard.no_early_req", 15, 0);
    step(1);
    chk1("rst_guard.timeout_req", user_stdby, 1'b1);

    // periodic activity keeps the idle timer from expiring
    do_reset();
    for (int i = 0; i < 60; i++) begin
      activity = ((i % 10) == 9);
      step(1);
      if (user_stdby) begin
        n_chk++;
        n_fail++;
        $display("FAIL activity.user_stdby: got 1 at cycle %0d, required 0", i + 1);
      end
    end
    activity = 1'b0;
    chk1("activity.user_end", user_stdby, 1'b0);

    // bouncing button never settles long enough to register
    activity = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      stdby_req_n = ((i / 2) % 2) != 0;
      step(1);
    end
    stdby_req_n = 1'b1;
    n_chk++;
    count_user("bounce.no_req", 12, 0);
    n_chk--;
    activity = 1'b0;

    // sleep counter saturates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sleep_cycle();
      if (i == 254) chk8("sat.cnt_255", stdby_cnt, 8'hFF);
    end
    chk8("sat.cnt_300", stdby_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
